// File: rtl/gps_pkg.sv
// Shared constants, types and helpers for the GPS L1 C/A code generator.
// The G2 phase-selector table packs each (s1,s2) tap pair as two nibbles.
package gps_pkg;

   localparam int CODE_LEN = 1023;
   localparam int NUM_PRN  = 32;

   typedef logic [9:0] chip_idx_t;
   typedef logic [5:0] prn_t;

   typedef struct packed {
      logic [3:0] s1;
      logic [3:0] s2;
   } tap_pair_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } gen_state_t;

   localparam logic [9:0] LFSR_INIT = 10'h3FF;
   // Bit k-1 set means stage k feeds back: G1 = x^3+x^10, G2 = x^2+x^3+x^6+x^8+x^9+x^10.
   localparam logic [9:0] G1_MASK   = 10'h204;
   localparam logic [9:0] G2_MASK   = 10'h3A6;

   localparam logic [7:0] G2_TAPS [0:31] = '{
      8'h26, 8'h37, 8'h48, 8'h59, 8'h19, 8'h2A, 8'h18, 8'h29,
      8'h3A, 8'h23, 8'h34, 8'h56, 8'h67, 8'h78, 8'h89, 8'h9A,
      8'h14, 8'h25, 8'h36, 8'h47, 8'h58, 8'h69, 8'h13, 8'h46,
      8'h57, 8'h68, 8'h79, 8'h8A, 8'h16, 8'h27, 8'h38, 8'h49
   };

   function automatic logic parity10(input logic [9:0] v);
      return ^v;
   endfunction

   function automatic logic prn_valid(input prn_t p, input int num_prn);
      return (p != 6'd0) && (int'(p) <= num_prn);
   endfunction

   function automatic tap_pair_t prn_taps(input prn_t p);
      logic [4:0] idx;
      idx = 5'(p - 6'd1);
      return tap_pair_t'(G2_TAPS[idx]);
   endfunction

endpackage

// File: rtl/ca_lfsr10.sv
// 10-bit Fibonacci LFSR: stage 1 is bit 0, new feedback enters stage 1,
// stage 10 (bit 9) is the oldest bit. Load-ones has priority over shift.
module ca_lfsr10
   import gps_pkg::*;
#(
   parameter logic [9:0] TAP_MASK = 10'h204
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       load_ones,
   input  logic       shift_en,
   output logic [9:0] lfsr_state
);

   logic [9:0] lfsr_r;

   // Shift register with reload to the all-ones code-start value
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         lfsr_r <= LFSR_INIT;
      end else if (load_ones) begin
         lfsr_r <= LFSR_INIT;
      end else if (shift_en) begin
         lfsr_r <= {lfsr_r[8:0], parity10(lfsr_r & TAP_MASK)};
      end else begin
         lfsr_r <= lfsr_r;
      end
   end

   assign lfsr_state = lfsr_r;

endmodule

// File: rtl/ca_code_generator.sv
// GPS L1 C/A Gold code generator with epoch-aligned PRN switching.
// A PRN request made while running is held pending and applied only at the chip 1022 -> 0 wrap.
module ca_code_generator
   import gps_pkg::*;
#(
   parameter int CODE_LEN = gps_pkg::CODE_LEN,
   parameter int NUM_PRN  = gps_pkg::NUM_PRN
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       CHIP_EN,
   input  logic [5:0] PRN,
   input  logic       PRN_LOAD,
   output logic       CODE_OUT,
   output logic       EPOCH,
   output logic [9:0] CHIP_INDEX,
   output logic       VALID,
   output logic [5:0] ACTIVE_PRN
);

   localparam chip_idx_t LAST_CHIP_C = chip_idx_t'(CODE_LEN - 1);

   gen_state_t state_r, state_nxt_s;
   prn_t       active_prn_r, active_prn_nxt_s;
   prn_t       pend_prn_r, pend_prn_nxt_s;
   logic       pend_flag_r, pend_flag_nxt_s;
   chip_idx_t  chip_idx_r, chip_idx_nxt_s;
   logic       lfsr_load_s, lfsr_shift_s;
   prn_t       wrap_prn_s;
   logic [9:0] g1_s, g2_s;
   tap_pair_t  taps_s;
   logic [3:0] sel1_s, sel2_s;
   logic       valid_s;

   // State, PRN and chip-index registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_r      <= ST_IDLE;
         active_prn_r <= 6'd0;
         pend_prn_r   <= 6'd0;
         pend_flag_r  <= 1'b0;
         chip_idx_r   <= 10'd0;
      end else begin
         state_r      <= state_nxt_s;
         active_prn_r <= active_prn_nxt_s;
         pend_prn_r   <= pend_prn_nxt_s;
         pend_flag_r  <= pend_flag_nxt_s;
         chip_idx_r   <= chip_idx_nxt_s;
      end
   end

   // Next-state logic: start, chip advance, pending capture and wrap-time PRN switch
   always_comb begin
      state_nxt_s      = state_r;
      active_prn_nxt_s = active_prn_r;
      pend_prn_nxt_s   = pend_prn_r;
      pend_flag_nxt_s  = pend_flag_r;
      chip_idx_nxt_s   = chip_idx_r;
      lfsr_load_s      = 1'b0;
      lfsr_shift_s     = 1'b0;
      wrap_prn_s       = active_prn_r;
      case (state_r)
         ST_IDLE: begin
            if (PRN_LOAD && prn_valid(PRN, NUM_PRN)) begin
               state_nxt_s      = ST_RUN;
               active_prn_nxt_s = PRN;
               chip_idx_nxt_s   = 10'd0;
               lfsr_load_s      = 1'b1;
               pend_flag_nxt_s  = 1'b0;
               pend_prn_nxt_s   = 6'd0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (CHIP_EN && (chip_idx_r == LAST_CHIP_C)) begin
               // A same-cycle request wins over anything already pending
               if (PRN_LOAD) begin
                  wrap_prn_s = PRN;
               end else if (pend_flag_r) begin
                  wrap_prn_s = pend_prn_r;
               end else begin
                  wrap_prn_s = active_prn_r;
               end
               lfsr_load_s     = 1'b1;
               chip_idx_nxt_s  = 10'd0;
               pend_flag_nxt_s = 1'b0;
               pend_prn_nxt_s  = 6'd0;
               if (prn_valid(wrap_prn_s, NUM_PRN)) begin
                  state_nxt_s      = ST_RUN;
                  active_prn_nxt_s = wrap_prn_s;
               end else begin
                  state_nxt_s      = ST_IDLE;
                  active_prn_nxt_s = 6'd0;
               end
            end else begin
               if (CHIP_EN) begin
                  lfsr_shift_s   = 1'b1;
                  chip_idx_nxt_s = chip_idx_t'(chip_idx_r + 10'd1);
               end else begin
                  chip_idx_nxt_s = chip_idx_r;
               end
               if (PRN_LOAD) begin
                  pend_prn_nxt_s  = PRN;
                  pend_flag_nxt_s = 1'b1;
               end else begin
                  pend_flag_nxt_s = pend_flag_r;
               end
            end
         end
         default: begin
            state_nxt_s      = ST_IDLE;
            active_prn_nxt_s = 6'd0;
            pend_flag_nxt_s  = 1'b0;
            pend_prn_nxt_s   = 6'd0;
            chip_idx_nxt_s   = 10'd0;
            lfsr_load_s      = 1'b1;
         end
      endcase
   end

   ca_lfsr10 #(.TAP_MASK(G1_MASK)) u_g1 (
      .CLK        (CLK),
      .RESET      (RESET),
      .load_ones  (lfsr_load_s),
      .shift_en   (lfsr_shift_s),
      .lfsr_state (g1_s)
   );

   ca_lfsr10 #(.TAP_MASK(G2_MASK)) u_g2 (
      .CLK        (CLK),
      .RESET      (RESET),
      .load_ones  (lfsr_load_s),
      .shift_en   (lfsr_shift_s),
      .lfsr_state (g2_s)
   );

   // Tap numbers are 1-based stage numbers; stage k lives in bit k-1
   assign taps_s  = prn_taps(active_prn_r);
   assign sel1_s  = 4'(taps_s.s1 - 4'd1);
   assign sel2_s  = 4'(taps_s.s2 - 4'd1);
   assign valid_s = (state_r == ST_RUN);

   assign VALID      = valid_s;
   assign ACTIVE_PRN = active_prn_r;
   assign CHIP_INDEX = chip_idx_r;
   assign EPOCH      = valid_s && (chip_idx_r == 10'd0);
   assign CODE_OUT   = valid_s & (g1_s[9] ^ g2_s[sel1_s] ^ g2_s[sel2_s]);

endmodule

// File: tb/tb_ca_code_generator.sv
// Directed bench for ca_code_generator: first-chip table, period and epoch spacing,
// epoch-aligned PRN switching, idle transitions, CHIP_EN hold and asynchronous reset.
module tb_ca_code_generator;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       CHIP_EN = 1'b0;
   logic [5:0] PRN = 6'd0;
   logic       PRN_LOAD = 1'b0;
   logic       CODE_OUT;
   logic       EPOCH;
   logic [9:0] CHIP_INDEX;
   logic       VALID;
   logic [5:0] ACTIVE_PRN;

   int n_checks = 0;
   int n_errors = 0;
   bit model_seq [0:1022];

   typedef struct {
      logic [5:0] prn;
      logic       exp_valid;
      logic [9:0] exp_code;
   } vec_t;
   vec_t vecs [0:4];

   ca_code_generator dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .CHIP_EN    (CHIP_EN),
      .PRN        (PRN),
      .PRN_LOAD   (PRN_LOAD),
      .CODE_OUT   (CODE_OUT),
      .EPOCH      (EPOCH),
      .CHIP_INDEX (CHIP_INDEX),
      .VALID      (VALID),
      .ACTIVE_PRN (ACTIVE_PRN)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET = 1'b1;
      PRN_LOAD = 1'b0;
      CHIP_EN = 1'b1;
      tick();
      RESET = 1'b0;
   endtask

   task automatic load_prn(input logic [5:0] p);
      PRN = p;
      PRN_LOAD = 1'b1;
      tick();
      PRN_LOAD = 1'b0;
   endtask

   task automatic run_until(input int target);
      int b;
      b = 0;
      while (int'(CHIP_INDEX) != target && b < 3000) begin
         tick();
         b++;
      end
      check("reach_index", 32'(CHIP_INDEX), 32'(target));
   endtask

   // Reference Gold code: stages numbered 1..10, output from G1 stage 10
   task automatic build_model(input int prn);
      int g1 [1:10];
      int g2 [1:10];
      int s1, s2, f1, f2;
      case (prn)
         1: begin s1 = 2; s2 = 6; end
         2: begin s1 = 3; s2 = 7; end
         4: begin s1 = 5; s2 = 9; end
         5: begin s1 = 1; s2 = 9; end
         default: begin s1 = 2; s2 = 6; end
      endcase
      for (int j = 1; j <= 10; j++) begin
         g1[j] = 1;
         g2[j] = 1;
      end
      for (int k = 0; k < 1023; k++) begin
         model_seq[k] = bit'(g1[10] ^ g2[s1] ^ g2[s2]);
         f1 = g1[3] ^ g1[10];
         f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
         for (int j = 10; j >= 2; j--) begin
            g1[j] = g1[j-1];
            g2[j] = g2[j-1];
         end
         g1[1] = f1;
         g2[1] = f2;
      end
   endtask

   initial begin
      logic [9:0] word, ep_word;
      int mism, ep_cnt, exp_idx, en;
      int ep_at [0:2];

      // PRN 5 uses taps (1,9): first ten chips 1001011011 (octal 1133)
      vecs[0] = '{prn: 6'd1,  exp_valid: 1'b1, exp_code: 10'o1440};
      vecs[1] = '{prn: 6'd2,  exp_valid: 1'b1, exp_code: 10'o1620};
      vecs[2] = '{prn: 6'd4,  exp_valid: 1'b1, exp_code: 10'o1744};
      vecs[3] = '{prn: 6'd5,  exp_valid: 1'b1, exp_code: 10'o1133};
      vecs[4] = '{prn: 6'd40, exp_valid: 1'b0, exp_code: 10'o0000};

      // Reset state
      #3;
      check("rst_code", 32'(CODE_OUT), 32'd0);
      check("rst_epoch", 32'(EPOCH), 32'd0);
      check("rst_index", 32'(CHIP_INDEX), 32'd0);
      check("rst_valid", 32'(VALID), 32'd0);
      check("rst_active", 32'(ACTIVE_PRN), 32'd0);

      // First ten chips for each table entry
      for (int v = 0; v < 5; v++) begin
         do_reset();
         load_prn(vecs[v].prn);
         word = 10'd0;
         ep_word = 10'd0;
         check("tbl_valid", 32'(VALID), 32'(vecs[v].exp_valid));
         check("tbl_active", 32'(ACTIVE_PRN), vecs[v].exp_valid ? 32'(vecs[v].prn) : 32'd0);
         for (int c = 0; c < 10; c++) begin
            word = {word[8:0], CODE_OUT};
            ep_word = {ep_word[8:0], EPOCH};
            tick();
         end
         check("tbl_code", 32'(word), 32'(vecs[v].exp_code));
         check("tbl_epoch", 32'(ep_word), vecs[v].exp_valid ? 32'h200 : 32'd0);
      end

      // Three full periods of PRN 1
      do_reset();
      build_model(1);
      load_prn(6'd1);
      mism = 0;
      ep_cnt = 0;
      for (int i = 0; i < 3; i++) ep_at[i] = -1;
      for (int i = 0; i < 3069; i++) begin
         if (CODE_OUT !== model_seq[i % 1023] || int'(CHIP_INDEX) != i % 1023
             || EPOCH !== (i % 1023 == 0)) mism++;
         if (EPOCH === 1'b1) begin
            if (ep_cnt < 3) ep_at[ep_cnt] = i;
            ep_cnt++;
         end
         tick();
      end
      check("period_mismatch", 32'(mism), 32'd0);
      check("epoch_count", 32'(ep_cnt), 32'd3);
      check("epoch_gap1", 32'(ep_at[1] - ep_at[0]), 32'd1023);
      check("epoch_gap2", 32'(ep_at[2] - ep_at[1]), 32'd1023);

      // Pending PRN requests at chip 500: the later one (5) wins at the wrap
      do_reset();
      build_model(1);
      load_prn(6'd1);
      run_until(500);
      PRN = 6'd2;
      PRN_LOAD = 1'b1;
      tick();
      PRN = 6'd5;
      tick();
      PRN_LOAD = 1'b0;
      mism = 0;
      for (int k = 502; k < 1023; k++) begin
         if (CODE_OUT !== model_seq[k] || ACTIVE_PRN !== 6'd1 || int'(CHIP_INDEX) != k) mism++;
         tick();
      end
      check("old_prn_tail", 32'(mism), 32'd0);
      check("switch_active", 32'(ACTIVE_PRN), 32'd5);
      check("switch_epoch", 32'(EPOCH), 32'd1);
      build_model(5);
      mism = 0;
      word = 10'd0;
      for (int k = 0; k < 1023; k++) begin
         if (k < 10) word = {word[8:0], CODE_OUT};
         if (CODE_OUT !== model_seq[k]) mism++;
         // Request PRN 0 mid-period: block must go idle at the wrap
         PRN = 6'd0;
         PRN_LOAD = (k == 300);
         tick();
      end
      PRN_LOAD = 1'b0;
      check("prn5_first10", 32'(word), 32'(10'o1133));
      check("prn5_period", 32'(mism), 32'd0);
      check("idle_valid", 32'(VALID), 32'd0);
      check("idle_active", 32'(ACTIVE_PRN), 32'd0);
      check("idle_code", 32'(CODE_OUT), 32'd0);
      check("idle_epoch", 32'(EPOCH), 32'd0);
      load_prn(6'd40);
      tick();
      check("bad_prn_valid", 32'(VALID), 32'd0);
      check("bad_prn_active", 32'(ACTIVE_PRN), 32'd0);

      // Same-cycle load at the wrap bypasses the pending PRN
      load_prn(6'd1);
      check("restart_active", 32'(ACTIVE_PRN), 32'd1);
      run_until(5);
      load_prn(6'd2);
      run_until(1022);
      load_prn(6'd4);
      check("bypass_active", 32'(ACTIVE_PRN), 32'd4);
      word = 10'd0;
      for (int c = 0; c < 10; c++) begin
         word = {word[8:0], CODE_OUT};
         tick();
      end
      check("bypass_first10", 32'(word), 32'(10'o1744));
      // Reloading the PRN in use is invisible
      load_prn(6'd4);
      run_until(1022);
      tick();
      check("same_prn_active", 32'(ACTIVE_PRN), 32'd4);
      check("same_prn_epoch", 32'(EPOCH), 32'd1);
      check("same_prn_code", 32'(CODE_OUT), 32'd1);

      // Random CHIP_EN: outputs hold when disabled, advance when enabled
      do_reset();
      build_model(1);
      load_prn(6'd1);
      exp_idx = 0;
      mism = 0;
      for (int b = 0; b < 5000 && int'(CHIP_INDEX) != 700; b++) begin
         en = int'($urandom_range(0, 1));
         CHIP_EN = 1'(en);
         tick();
         if (en == 1) exp_idx = (exp_idx + 1) % 1023;
         if (int'(CHIP_INDEX) != exp_idx || CODE_OUT !== model_seq[exp_idx]
             || EPOCH !== (exp_idx == 0)) mism++;
      end
      check("chip_en_hold", 32'(mism), 32'd0);
      check("reached_700", 32'(CHIP_INDEX), 32'd700);
      // Asynchronous reset between clock edges
      #2;
      RESET = 1'b1;
      #1;
      check("arst_code", 32'(CODE_OUT), 32'd0);
      check("arst_epoch", 32'(EPOCH), 32'd0);
      check("arst_index", 32'(CHIP_INDEX), 32'd0);
      check("arst_valid", 32'(VALID), 32'd0);
      check("arst_active", 32'(ACTIVE_PRN), 32'd0);
      @(negedge CLK);
      RESET = 1'b0;
      CHIP_EN = 1'b1;
      tick();
      check("post_rst_valid", 32'(VALID), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
